logic16_arbiter: RTL and testbench

LOGIC16_ARBITER -- requirements
Module: logic16_arbiter

---
 rtl/logic16_arbiter.sv | 135 +++++++++++++
 tb/tb_logic16_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/logic16_arbiter.sv
// Two-requester logic unit: arbitrates between requesters with a toggling
// priority pointer, executes one NOT/AND/OR/pass operation at a time and
// returns the result to the granted requester with a valid/ready handshake.
module logic16_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             grant_id
);

  localparam int unsigned OPW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OPW-1:0] OP_NOT  = 2'b00;
  localparam logic [OPW-1:0] OP_AND  = 2'b01;
  localparam logic [OPW-1:0] OP_OR   = 2'b10;

  state_t           state;
  logic             prio;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             winner;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] result;

  // Winner: a lone requester wins outright, otherwise the priority pointer decides
  always_comb begin
    winner = 1'b0;
    if (req_valid == 2'b11) begin
      winner = prio;
    end else begin
      winner = req_valid[1];
    end
  end

  // Operand mux for the requester being granted this cycle
  always_comb begin
    sel_op = req_op0;
    sel_a  = req_a0;
    sel_b  = req_b0;
    if (winner) begin
      sel_op = req_op1;
      sel_a  = req_a1;
      sel_b  = req_b1;
    end
  end

  // Accept strobe is combinational so the grant is visible in the accept cycle
  always_comb begin
    req_ready = 2'b00;
    if (!rst && state == IDLE && req_valid != 2'b00) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
  end

  // Logic operation on the captured operands
  always_comb begin
    result = a_q;
    case (op_q)
      OP_NOT:  result = ~a_q;
      OP_AND:  result = a_q & b_q;
      OP_OR:   result = a_q | b_q;
      default: result = a_q;
    endcase
  end

  // Control FSM with registered outputs; operands are frozen once accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      grant_id  <= 1'b0;
      rsp_data  <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 2'b00;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid != 2'b00) begin
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
            grant_id <= winner;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= result;
          rsp_valid <= grant_id ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            prio      <= ~grant_id;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic16_arbiter.sv
// Directed self-checking bench for logic16_arbiter.
module tb_logic16_arbiter;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_op0;
  logic [1:0]       req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic             grant_id;

  int n_cmp;
  int n_bad;

  logic [1:0]       o_rdy;
  logic [1:0]       o_rv;
  logic [WIDTH-1:0] o_rd;
  logic             o_gid;

  logic16_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full transaction with immediate handshake; returns what was observed.
  // Called just after a negedge; returns just after a negedge in IDLE.
  task automatic run_txn(input logic [1:0] v,
                         input logic [1:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [1:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                         output logic [1:0] rdy, output logic [1:0] rv,
                         output logic [15:0] rd, output logic gid);
    req_valid = v;
    req_op0 = op0; req_a0 = a0; req_b0 = b0;
    req_op1 = op1; req_a1 = a1; req_b1 = b1;
    #1;
    rdy = req_ready;
    @(posedge clk); @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); @(negedge clk);
    rv  = rsp_valid;
    rd  = rsp_data;
    gid = grant_id;
    rsp_ready = rv;
    @(posedge clk); @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    req_op0 = 2'b00; req_op1 = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (rsp_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
    n_cmp++; if (grant_id !== 1'b0) begin n_bad++; $display("FAIL reset_grant_id got=%b exp=0", grant_id); end
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_not();
    run_txn(2'b01, 2'b00, 16'h00FF, 16'h0000, 2'b11, 16'h0000, 16'h0000, o_rdy, o_rv, o_rd, o_gid);
    n_cmp++; if (o_rdy !== 2'b01) begin n_bad++; $display("FAIL not_req_ready got=%b exp=01", o_rdy); end
    n_cmp++; if (o_rv !== 2'b01) begin n_bad++; $display("FAIL not_rsp_valid got=%b exp=01", o_rv); end
    n_cmp++; if (o_rd !== 16'hFF00) begin n_bad++; $display("FAIL not_rsp_data got=%h exp=ff00", o_rd); end
    n_cmp++; if (o_gid !== 1'b0) begin n_bad++; $display("FAIL not_grant_id got=%b exp=0", o_gid); end
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_bad++; $display("FAIL not_idle busy=%b rsp_valid=%b exp 0/00", busy, rsp_valid); end
    n_cmp++; if (rsp_data !== 16'hFF00) begin n_bad++; $display("FAIL not_data_retained got=%h exp=ff00", rsp_data); end
    // prio is now 1: under contention requester 1 must win
    run_txn(2'b11, 2'b11, 16'h1111, 16'h0000, 2'b11, 16'h2222, 16'h0000, o_rdy, o_rv, o_rd, o_gid);
    n_cmp++; if (o_rdy !== 2'b10) begin n_bad++; $display("FAIL not_prio_after got=%b exp=10", o_rdy); end
    n_cmp++; if (o_rd !== 16'h2222) begin n_bad++; $display("FAIL not_prio_data got=%h exp=2222", o_rd); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy [3];
    logic [15:0] exp_rd  [3];
    exp_rdy[0] = 2'b01; exp_rd[0] = 16'hAAAA;
    exp_rdy[1] = 2'b10; exp_rd[1] = 16'h5555;
    exp_rdy[2] = 2'b01; exp_rd[2] = 16'hAAAA;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_txn(2'b11, 2'b11, 16'hAAAA, 16'h0000, 2'b11, 16'h5555, 16'h0000, o_rdy, o_rv, o_rd, o_gid);
      n_cmp++; if (o_rdy !== exp_rdy[i]) begin n_bad++; $display("FAIL cont_ready[%0d] got=%b exp=%b", i, o_rdy, exp_rdy[i]); end
      n_cmp++; if (o_rv !== exp_rdy[i]) begin n_bad++; $display("FAIL cont_valid[%0d] got=%b exp=%b", i, o_rv, exp_rdy[i]); end
      n_cmp++; if (o_rd !== exp_rd[i]) begin n_bad++; $display("FAIL cont_data[%0d] got=%h exp=%h", i, o_rd, exp_rd[i]); end
    end
  endtask

  task automatic test_ops();
    logic [15:0] exp_rd [4];
    exp_rd[0] = 16'h0F0F; exp_rd[1] = 16'h00F0; exp_rd[2] = 16'hFFF0; exp_rd[3] = 16'hF0F0;
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b10, 2'b00, 16'h0000, 16'h0000, 2'(i), 16'hF0F0, 16'h0FF0, o_rdy, o_rv, o_rd, o_gid);
      n_cmp++; if (o_rd !== exp_rd[i]) begin n_bad++; $display("FAIL op1_%0d got=%h exp=%h", i, o_rd, exp_rd[i]); end
      n_cmp++; if (o_gid !== 1'b1 || o_rv !== 2'b10) begin n_bad++; $display("FAIL op1_route_%0d gid=%b rv=%b exp 1/10", i, o_gid, o_rv); end
    end
    run_txn(2'b01, 2'b01, 16'h3C3C, 16'hFF00, 2'b00, 16'h0000, 16'h0000, o_rdy, o_rv, o_rd, o_gid);
    n_cmp++; if (o_rd !== 16'h3C00) begin n_bad++; $display("FAIL op0_and got=%h exp=3c00", o_rd); end
  endtask

  task automatic test_backpressure();
    req_valid = 2'b01; req_op0 = 2'b10; req_a0 = 16'h1200; req_b0 = 16'h0034;
    @(posedge clk); @(negedge clk);
    req_valid = 2'b11; req_a0 = 16'hDEAD; req_b0 = 16'hBEEF; req_op0 = 2'b00;
    req_a1 = 16'h7777; req_op1 = 2'b11;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req_a0 = 16'(i * 16'h1111);
      n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL bp_valid[%0d] got=%b exp=01", i, rsp_valid); end
      n_cmp++; if (rsp_data !== 16'h1234) begin n_bad++; $display("FAIL bp_data[%0d] got=%h exp=1234", i, rsp_data); end
      n_cmp++; if (busy !== 1'b1 || req_ready !== 2'b00) begin n_bad++; $display("FAIL bp_busy[%0d] busy=%b ready=%b exp 1/00", i, busy, req_ready); end
      @(posedge clk); @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    @(posedge clk); @(negedge clk);
    rsp_ready = 2'b00;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_bad++; $display("FAIL bp_done busy=%b rv=%b exp 0/00", busy, rsp_valid); end
  endtask

  task automatic test_stray_ready();
    req_valid = 2'b01; req_op0 = 2'b11; req_a0 = 16'h4242;
    @(posedge clk); @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); @(negedge clk);
    rsp_ready = 2'b10;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL stray_valid got=%b exp=01", rsp_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stray_busy got=%b exp=1", busy); end
    n_cmp++; if (rsp_data !== 16'h4242) begin n_bad++; $display("FAIL stray_data got=%h exp=4242", rsp_data); end
    rsp_ready = 2'b01;
    @(posedge clk); @(negedge clk);
    rsp_ready = 2'b00;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stray_done busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    do_reset();
    // move prio to 1 first so its reset is observable
    run_txn(2'b01, 2'b11, 16'h0101, 16'h0000, 2'b11, 16'h0000, 16'h0000, o_rdy, o_rv, o_rd, o_gid);
    req_valid = 2'b10; req_op1 = 2'b11; req_a1 = 16'h9999;
    @(posedge clk); @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;
    rsp_ready = 2'b11;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL mid_valid got=%b exp=00", rsp_valid); end
    n_cmp++; if (rsp_data !== 16'h0000) begin n_bad++; $display("FAIL mid_data got=%h exp=0000", rsp_data); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 2'b00) seen = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 2'b00;
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_response got=%b exp=0", seen); end
    run_txn(2'b11, 2'b11, 16'hA0A0, 16'h0000, 2'b11, 16'hB0B0, 16'h0000, o_rdy, o_rv, o_rd, o_gid);
    n_cmp++; if (o_rdy !== 2'b01) begin n_bad++; $display("FAIL mid_prio got=%b exp=01", o_rdy); end
    n_cmp++; if (o_rd !== 16'hA0A0) begin n_bad++; $display("FAIL mid_after_data got=%h exp=a0a0", o_rd); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_not();
    test_contention();
    test_ops();
    test_backpressure();
    test_stray_ready();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
